// File: rtl/aes_pkg.sv
// Shared AES constants, sequencer state encoding and a sizing helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  // Sequencer states, 2-bit encoded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Ceiling log2, used to size beat counters at elaboration time.
  function automatic int aes_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_aes_sbox_fwd.sv
// Combinational AES forward S-box implemented as a constant lookup table.
module bp_aes_sbox_fwd (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry for input 0x00 sits in the most significant byte; entry for 0xff in the least.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table offset for byte v is (255 - v) * 8, and 255 - v is simply ~v.
  assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_subbytes_seq.sv
// AES SubBytes sequencer: buffers one 128-bit state and substitutes it LANES bytes per cycle.
module aes_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int BEATS     = AES_BYTES / LANES;
  localparam int CNT_LOG   = aes_clog2(BEATS);
  localparam int CNT_W     = (CNT_LOG > 1) ? CNT_LOG : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0]  buf_q, buf_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [LANES*8-1:0]      lane_out;
  logic [AES_BLOCK_W-1:0]  sub_state;

  // One S-box per lane; each lane picks its byte of the current beat from the buffer only.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_in;

    // Byte mux: beat b feeds buffer byte b*LANES+gi into this lane.
    always_comb begin
      lane_in = buf_q[gi*8 +: 8];
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          lane_in = buf_q[(b*LANES + gi)*8 +: 8];
        end
      end
    end

    bp_aes_sbox_fwd u_sbox (
      .in_byte  (lane_in),
      .out_byte (lane_out[gi*8 +: 8])
    );
  end

  // Write-back image: bytes of the active beat take their lane result, the rest keep their value.
  for (genvar gi = 0; gi < AES_BYTES; gi++) begin : g_byte
    localparam logic [CNT_W-1:0] BYTE_BEAT = CNT_W'(gi / LANES);
    localparam int               BYTE_LANE = gi % LANES;
    assign sub_state[gi*8 +: 8] = (cnt_q == BYTE_BEAT) ? lane_out[BYTE_LANE*8 +: 8]
                                                       : buf_q[gi*8 +: 8];
  end

  // Next-state, buffer and counter logic; in_ready follows out_ready only while DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        buf_d = sub_state;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            buf_d   = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State, counter, buffer and registered status flags; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = buf_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq: vector table, corner sequences and a random stream.
module tb_aes_subbytes_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: LANES=4, index 1: LANES=1, index 2: LANES=16.
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  aes_subbytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  aes_subbytes_seq #(.LANES(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  aes_subbytes_seq #(.LANES(16)) dut_l16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2])
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model: S-box from GF(2^8) inverse + affine map ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, sq;
    int e;
    inv = 8'h01; sq = a; e = 254;
    for (int k = 0; k < 8; k++) begin
      if ((e >> k) & 1) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] block_ref(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_ref(d[i*8 +: 8]);
    return r;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chkint(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  // Wait (at negedges) until out_valid of instance k rises; bounded.
  task automatic wait_out_valid(input int k, input string name);
    int guard;
    guard = 0;
    while (!out_valid[k] && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid[k]) timeout_fail(name);
  endtask

  // Push one block into instance k, measure BUSY cycles, collect the result and consume it.
  task automatic run_block(input int k, input logic [127:0] d,
                           output logic [127:0] res, output int lat);
    int guard;
    @(negedge clk);
    in_data[k]   = d;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b0;
    #1;
    guard = 0;
    while (!in_ready[k] && guard < 60) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready[k]) timeout_fail("accept_wait");
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat   = 0;
    guard = 0;
    while (!out_valid[k] && guard < 60) begin
      if (busy[k]) lat++;
      @(negedge clk);
      guard++;
    end
    if (!out_valid[k]) timeout_fail("result_wait");
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs[4];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] res, a_blk, b_blk, held;
    logic [127:0] expq[$];
    int lat, sent, recv, guard;
    bit stalled, acc;
    int lanes_of[3];
    lanes_of[0] = 4; lanes_of[1] = 1; lanes_of[2] = 16;

    vecs[0].din  = 128'h0;
    vecs[0].dout = {16{8'h63}};
    vecs[1].din  = FIPS_IN;
    vecs[1].dout = FIPS_OUT;
    vecs[2].din  = 128'h0f0e0d0c0b0a09080706050403020100;
    vecs[2].dout = 128'h76abd7fe2b670130c56f6bf27b777c63;
    vecs[3].din  = 128'h53ff0000000000000000ff0000530000;
    vecs[3].dout = 128'hed166363636363636363166363ed6363;

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chkint($sformatf("rst_in_ready%0d", k), int'(in_ready[k]), 1);
      chkint($sformatf("rst_out_valid%0d", k), int'(out_valid[k]), 0);
      chkint($sformatf("rst_busy%0d", k), int'(busy[k]), 0);
      chk128($sformatf("rst_out_data%0d", k), out_data[k], 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors on the LANES=4 instance.
    foreach (vecs[v]) begin
      run_block(0, vecs[v].din, res, lat);
      chk128($sformatf("vec%0d_data", v), res, vecs[v].dout);
      chkint($sformatf("vec%0d_busy_cycles", v), lat, 4);
      $display("vec %0d in=%h out=%h busy_cycles=%0d", v, vecs[v].din, res, lat);
    end

    // Same FIPS state through LANES=1 and LANES=16.
    for (int k = 1; k < 3; k++) begin
      run_block(k, FIPS_IN, res, lat);
      chk128($sformatf("fips_lanes%0d", lanes_of[k]), res, FIPS_OUT);
      chkint($sformatf("fips_lat_lanes%0d", lanes_of[k]), lat, 16 / lanes_of[k]);
      $display("fips lanes=%0d out=%h busy_cycles=%0d", lanes_of[k], res, lat);
    end

    // Backpressure: hold result while a new block waits, then accept it with no bubble.
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    b_blk = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = a_blk; out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = b_blk;
    wait_out_valid(0, "bp_first_valid");
    for (int c = 0; c < 10; c++) begin
      #1;
      chkint("bp_in_ready_stall", int'(in_ready[0]), 0);
      chkint("bp_out_valid_stall", int'(out_valid[0]), 1);
      chk128("bp_out_data_stall", out_data[0], block_ref(a_blk));
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    chkint("bp_in_ready_release", int'(in_ready[0]), 1);
    $display("backpressure held=%h", out_data[0]);
    @(negedge clk);
    chkint("bp_busy_no_bubble", int'(busy[0]), 1);
    chkint("bp_out_valid_drop", int'(out_valid[0]), 0);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    wait_out_valid(0, "bp_second_valid");
    chk128("bp_second_data", out_data[0], block_ref(b_blk));
    $display("backpressure second=%h", out_data[0]);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Asynchronous reset with the counter at 2.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = a_blk;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chkint("midrst_out_valid", int'(out_valid[0]), 0);
    chkint("midrst_in_ready", int'(in_ready[0]), 1);
    chkint("midrst_busy", int'(busy[0]), 0);
    chk128("midrst_out_data", out_data[0], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, FIPS_IN, res, lat);
    chk128("postrst_data", res, FIPS_OUT);
    chkint("postrst_lat", lat, 4);
    $display("post-reset out=%h busy_cycles=%0d", res, lat);

    // Random stream with random valid/ready against the model scoreboard.
    sent = 0; recv = 0; stalled = 1'b0; acc = 1'b0; held = '0;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    guard = 0;
    while (recv < 1000 && guard < 40000) begin
      @(negedge clk);
      guard++;
      if (acc) begin
        in_valid[0] = 1'b0;
        acc = 1'b0;
      end
      if (sent < 1000 && !in_valid[0] && $urandom_range(0, 3) != 0) begin
        in_valid[0] = 1'b1;
        in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready[0] = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        chkint("stream_stall_valid", int'(out_valid[0]), 1);
        chk128("stream_stall_data", out_data[0], held);
      end
      if (in_valid[0] && in_ready[0]) begin
        expq.push_back(block_ref(in_data[0]));
        sent++;
        acc = 1'b1;
      end
      if (out_valid[0] && out_ready[0]) begin
        if (expq.size() == 0) begin
          timeout_fail("stream_unexpected_output");
        end else begin
          res = expq.pop_front();
          chk128("stream_data", out_data[0], res);
          $display("stream blk %0d out=%h", recv, out_data[0]);
        end
        recv++;
      end
      stalled = out_valid[0] && !out_ready[0];
      held    = out_data[0];
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chkint("stream_sent", sent, 1000);
    chkint("stream_recv", recv, 1000);
    chkint("stream_leftover", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
- Sequencer that applies the AES forward SubBytes transform to a full 128-bit state.
- Streams the 16 state bytes through LANES instances of the combinational forward S-box, LANES bytes per cycle.
- Sits between the round-state register/AddRoundKey stage (upstream) and ShiftRows/MixColumns (downstream).
- Uses valid/ready handshakes on both sides so the S-box area/throughput trade-off is set by one parameter.

Parameters:
- LANES, 4, number of S-box instances and bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- BEATS, 16/LANES, derived localparam: processing cycles per block.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a state.
- in_ready  out  1  block can accept a state this cycle.
- in_data  in  128  input state. Byte i = in_data[8i+7:8i].
- out_valid  out  1  substituted state available.
- out_ready  in  1  downstream accepts the output.
- out_data  out  128  output state. Byte i = S(in byte i).
- busy  out  1  high while in the BUSY state.

Behaviour:
- Reset (async, rst=1): state=IDLE, beat counter=0, data buffer=0. Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data into a 128-bit buffer, clear the counter, go to BUSY.
- State BUSY:
  - in_ready=0, busy=1.
  - Each cycle, lanes j=0..LANES-1 substitute buffer byte cnt*LANES+j and write the result back to the same byte position at the clock edge.
  - The counter increments; at cnt=BEATS-1 go to DONE and wrap the counter to 0.
  - in_valid is ignored.
- State DONE:
  - out_valid=1 and out_data=buffer, held stable until out_ready.
  - On out_ready: if in_valid is also high, in_ready=1 combinationally in this case only. Latch the new in_data and go straight to BUSY (back-to-back, no bubble). Otherwise go to IDLE.
  - in_ready = out_ready in DONE.
- Latency: input handshake at edge N gives out_valid high in the cycle after edge N+BEATS.
  - LANES=16: 1 BUSY cycle.
  - LANES=1: 16 BUSY cycles.
- Throughput: one block per BEATS+1 cycles under continuous out_ready.
- out_data must not change while out_valid=1 and out_ready=0.
- S-box lanes see only buffer bytes, never in_data directly. There is no combinational path from in_data to out_data.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready (DONE only).
- Reset asserted mid-BUSY or mid-DONE: abort immediately. The partial result is discarded and never presented.
- Unsubstituted and substituted bytes coexist in the buffer during BUSY. Only the final buffer is observable via out_data.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128.
  - AES_BYTES=16.
  - State enum {IDLE, BUSY, DONE} as 2-bit localparams.
  - A function returning clog2 for counter sizing. Counter width is max(1, clog2(BEATS)).
- Sub-module: bp_aes_sbox_fwd, instantiated LANES times in a generate loop. Each lane's input is selected by a byte mux indexed by the counter.
- No other sub-modules.

Test Plan:
- Reset then single block, LANES=4, in_data all 0x00, out_ready=1 → out_valid after exactly 4 BUSY cycles, out_data=0x6363...63 (16 bytes), busy high for 4 cycles.
- FIPS-197 round-1 state 0x193de3bea0f4e22b9ac68d2ae9f84808 → out_data=0xd42711aee0bf98f1b8b45de51e415230. Run for LANES=1, 4, 16 with identical result and latencies 16/4/1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, drive in_valid=1 with a different state → in_ready=0, out_data stable, no second acceptance; release out_ready → new state accepted in the same cycle, no idle cycle.
- Byte-position check: in_data with byte i = i (0x0f0e...0100) → out byte 0=0x63, byte 1=0x7c, byte 15=0x76. Also in byte 0x53→0xED and 0xFF→0x16 in arbitrary lanes.
- Reset mid-BUSY (assert rst asynchronously at cnt=2, off-edge) → out_valid=0, in_ready=1, busy=0 immediately. Next block processes correctly from count 0.
- Random stream of 1000 blocks with random in_valid/out_ready → scoreboard against a byte-wise S-box model, no drops or duplicates, out_data stable under stall.
